// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types for the UART response scheduler: FSM state encoding, source IDs
// and the round-robin arbitration rule.
package tx_frame_scheduler_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned BL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state_e;

    typedef enum logic {
        SRC_RD  = 1'b0,
        SRC_ALU = 1'b1
    } src_id_e;

    localparam logic [BL_W-1:0] BYTES_RD  = 2'd1;
    localparam logic [BL_W-1:0] BYTES_ALU = 2'd2;

    // A lone full slot wins outright; on a tie the source not served last time wins.
    function automatic src_id_e pick_src(input logic rd_full, input logic alu_full,
                                         input src_id_e rr_last);
        src_id_e src;
        src = SRC_RD;
        if (alu_full && rd_full) begin
            src = (rr_last == SRC_RD) ? SRC_ALU : SRC_RD;
        end else if (alu_full) begin
            src = SRC_ALU;
        end
        return src;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_resp_slot.sv
// One-deep response buffer: captures a strobed word, releases it on drain and
// flags a strobe that finds the slot occupied.
module resp_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] wdata,
    input  logic         strobe,
    input  logic         drain,
    output logic [W-1:0] data,
    output logic         full,
    output logic         full_nxt_c,
    output logic         ovf_c
);

    logic accept_c;

    // A drain in the same cycle frees the slot for the incoming word.
    assign accept_c = strobe && (!full || drain);
    assign ovf_c    = strobe && full && !drain;

    always_comb begin
        full_nxt_c = full;
        if (accept_c) begin
            full_nxt_c = 1'b1;
        end else if (drain) begin
            full_nxt_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            full <= full_nxt_c;
            if (accept_c) begin
                data <= wdata;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Buffers register-read and ALU responses, arbitrates between them and feeds
// them LSB-first, one byte at a time, to the UART transmitter.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned width   = 8,
    parameter int unsigned BUSY_TO = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [width-1:0]     RdData,
    input  logic                 Rd_valid,
    input  logic [2*width-1:0]   ALU_out,
    input  logic                 ALU_out_valid,
    input  logic                 Tx_Busy,
    output logic [width-1:0]     Tx_Data,
    output logic                 Tx_Data_valid,
    output logic                 Sched_busy,
    output logic                 Ovf_err
);

    localparam int unsigned FW    = 2 * width;
    localparam int unsigned CNT_W = $clog2(BUSY_TO + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TO - 1);

    sched_state_e          state;
    sched_state_e          state_nxt;
    logic [FW-1:0]         frame;
    logic [BL_W-1:0]       bytes_left;
    logic [CNT_W-1:0]      to_cnt;
    src_id_e               rr_last;
    src_id_e               serve_c;

    logic [width-1:0]      rd_data;
    logic                  rd_full;
    logic                  rd_full_nxt_c;
    logic                  rd_ovf_c;
    logic [FW-1:0]         alu_data;
    logic                  alu_full;
    logic                  alu_full_nxt_c;
    logic                  alu_ovf_c;

    logic                  rd_drain_c;
    logic                  alu_drain_c;
    logic                  rr_upd_c;
    logic                  issue_c;
    logic                  shift_c;
    logic                  cnt_inc_c;

    resp_slot #(.W(width)) u_rd_slot (
        .clk        (CLK),
        .rst_n      (RST),
        .wdata      (RdData),
        .strobe     (Rd_valid),
        .drain      (rd_drain_c),
        .data       (rd_data),
        .full       (rd_full),
        .full_nxt_c (rd_full_nxt_c),
        .ovf_c      (rd_ovf_c)
    );

    resp_slot #(.W(FW)) u_alu_slot (
        .clk        (CLK),
        .rst_n      (RST),
        .wdata      (ALU_out),
        .strobe     (ALU_out_valid),
        .drain      (alu_drain_c),
        .data       (alu_data),
        .full       (alu_full),
        .full_nxt_c (alu_full_nxt_c),
        .ovf_c      (alu_ovf_c)
    );

    assign serve_c = pick_src(rd_full, alu_full, rr_last);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a byte is retried if busy never rises within BUSY_TO cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_full || alu_full) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (Tx_Busy) begin
                    state_nxt = WAIT_LO;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = SEND;
                end
            end
            WAIT_LO: begin
                if (!Tx_Busy) begin
                    state_nxt = (bytes_left == BYTES_ALU) ? SEND : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        rd_drain_c  = 1'b0;
        alu_drain_c = 1'b0;
        rr_upd_c    = 1'b0;
        issue_c     = 1'b0;
        shift_c     = 1'b0;
        cnt_inc_c   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_full || alu_full) begin
                    alu_drain_c = (serve_c == SRC_ALU);
                    rd_drain_c  = (serve_c == SRC_RD);
                    rr_upd_c    = rd_full && alu_full;
                end
            end
            SEND: begin
                issue_c = 1'b1;
            end
            WAIT_HI: begin
                cnt_inc_c = !Tx_Busy;
            end
            WAIT_LO: begin
                shift_c = !Tx_Busy;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame         <= '0;
            bytes_left    <= '0;
            to_cnt        <= '0;
            rr_last       <= SRC_RD;
            Tx_Data       <= '0;
            Tx_Data_valid <= 1'b0;
            Ovf_err       <= 1'b0;
            Sched_busy    <= 1'b0;
        end else begin
            if (alu_drain_c) begin
                frame      <= alu_data;
                bytes_left <= BYTES_ALU;
            end else if (rd_drain_c) begin
                frame      <= FW'(rd_data);
                bytes_left <= BYTES_RD;
            end else if (shift_c) begin
                frame      <= frame >> width;
                bytes_left <= bytes_left - BL_W'(1);
            end

            if (rr_upd_c) begin
                rr_last <= serve_c;
            end

            if (issue_c) begin
                to_cnt <= '0;
            end else if (cnt_inc_c) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end

            Tx_Data_valid <= issue_c;
            if (issue_c) begin
                Tx_Data <= frame[width-1:0];
            end

            Ovf_err    <= rd_ovf_c || alu_ovf_c;
            Sched_busy <= (state_nxt != IDLE) || rd_full_nxt_c || alu_full_nxt_c;
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomised and directed bench for tx_frame_scheduler against a frame-level
// reference model and a simple UART busy responder.
module tb_tx_frame_scheduler;

    localparam int unsigned W  = 8;
    localparam int unsigned BT = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  RdData = '0;
    logic          Rd_valid = 1'b0;
    logic [2*W-1:0] ALU_out = '0;
    logic          ALU_out_valid = 1'b0;
    logic          Tx_Busy = 1'b0;
    logic [W-1:0]  Tx_Data;
    logic          Tx_Data_valid;
    logic          Sched_busy;
    logic          Ovf_err;

    tx_frame_scheduler #(.width(W), .BUSY_TO(BT)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RdData        (RdData),
        .Rd_valid      (Rd_valid),
        .ALU_out       (ALU_out),
        .ALU_out_valid (ALU_out_valid),
        .Tx_Busy       (Tx_Busy),
        .Tx_Data       (Tx_Data),
        .Tx_Data_valid (Tx_Data_valid),
        .Sched_busy    (Sched_busy),
        .Ovf_err       (Ovf_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART responder: busy rises u_rise cycles after a valid and stays high u_hold_cfg cycles.
    int u_dly = -1;
    int u_hold = 0;
    int u_rise = 0;
    int u_hold_cfg = 10;
    bit u_stuck = 1'b0;

    task automatic uart_update();
        if (Tx_Busy) begin
            if (u_hold <= 1) Tx_Busy = 1'b0;
            else u_hold--;
        end else if (u_dly == 0) begin
            Tx_Busy = 1'b1;
            u_hold  = u_hold_cfg;
            u_dly   = -1;
        end else if (u_dly > 0) begin
            u_dly--;
        end
        if (Tx_Data_valid && !u_stuck) u_dly = u_rise;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        Rd_valid      = 1'b0;
        ALU_out_valid = 1'b0;
        uart_update();
    endtask

    // Reference model, stepped once per cycle at the falling edge.
    int          cyc = 0;
    bit          m_rd_full, m_alu_full, m_last_alu;
    logic [7:0]  m_rd_q;
    logic [15:0] m_alu_q;
    logic [7:0]  m_bytes[$];
    int          m_left, m_send_due, m_retry_at;
    bit          m_wait_hi, prev_busy, exp_sb, exp_ovf;
    bit          mv_take_alu, mv_dr_rd, mv_dr_alu, mv_ovf_n, mv_ack, mv_exp_v;
    logic [7:0]  log_b[$];
    int          log_t[$];

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            m_rd_full = 0; m_alu_full = 0; m_last_alu = 0;
            m_bytes.delete();
            m_left = 0; m_send_due = -1; m_retry_at = -1; m_wait_hi = 0;
            exp_sb = 0; exp_ovf = 0; prev_busy = Tx_Busy;
            check("rst_valid", 32'(Tx_Data_valid), 32'd0);
        end else begin
            check("sched_busy", 32'(Sched_busy), 32'(exp_sb));
            check("ovf_err", 32'(Ovf_err), 32'(exp_ovf));
            mv_exp_v = (cyc == m_send_due) || (m_wait_hi && cyc == m_retry_at);
            check("tx_valid", 32'(Tx_Data_valid), 32'(mv_exp_v));
            if (Tx_Data_valid) begin
                log_b.push_back(Tx_Data);
                log_t.push_back(cyc);
                if (m_bytes.size() > 0) check("tx_data", 32'(Tx_Data), 32'(m_bytes[0]));
                m_wait_hi  = 1;
                m_retry_at = cyc + BT + 1;
            end
            if (Tx_Busy) m_wait_hi = 0;
            mv_ack = (m_left > 0) && prev_busy && !Tx_Busy;
            mv_dr_rd = 0; mv_dr_alu = 0; mv_ovf_n = 0;
            if (m_left == 0 && (m_rd_full || m_alu_full)) begin
                if (m_rd_full && m_alu_full) begin
                    mv_take_alu = !m_last_alu;
                    m_last_alu  = mv_take_alu;
                end else begin
                    mv_take_alu = m_alu_full;
                end
                if (mv_take_alu) begin
                    m_bytes.push_back(m_alu_q[7:0]);
                    m_bytes.push_back(m_alu_q[15:8]);
                    m_left = 2; mv_dr_alu = 1;
                end else begin
                    m_bytes.push_back(m_rd_q);
                    m_left = 1; mv_dr_rd = 1;
                end
                m_send_due = cyc + 2;
            end
            if (Rd_valid) begin
                if (!m_rd_full || mv_dr_rd) begin m_rd_q = RdData; m_rd_full = 1; end
                else mv_ovf_n = 1;
            end else if (mv_dr_rd) m_rd_full = 0;
            if (ALU_out_valid) begin
                if (!m_alu_full || mv_dr_alu) begin m_alu_q = ALU_out; m_alu_full = 1; end
                else mv_ovf_n = 1;
            end else if (mv_dr_alu) m_alu_full = 0;
            if (mv_ack) begin
                void'(m_bytes.pop_front());
                m_left--;
                if (m_left > 0) m_send_due = cyc + 2;
            end
            exp_sb    = (m_left > 0) || m_rd_full || m_alu_full;
            exp_ovf   = mv_ovf_n;
            prev_busy = Tx_Busy;
        end
    end

    task automatic send_rd(input logic [7:0] d);
        RdData = d; Rd_valid = 1'b1; tick();
    endtask

    task automatic send_alu(input logic [15:0] d);
        ALU_out = d; ALU_out_valid = 1'b1; tick();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((Sched_busy || Tx_Busy || u_dly >= 0) && n < max_cyc) begin
            tick(); n++;
        end
        check("idle_reached", 32'(Sched_busy), 32'd0);
        repeat (2) tick();
    endtask

    task automatic reset_pulse();
        RST = 1'b0; repeat (2) tick();
        RST = 1'b1; repeat (2) tick();
    endtask

    task automatic check_log(input string tag, input int n0, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] e [3];
        e[0] = b0; e[1] = b1; e[2] = b2;
        check($sformatf("%s_count", tag), 32'(log_b.size() - n0), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(log_b[n0 + i]), 32'(e[i]));
    endtask

    int n0, s, n;

    initial begin
        repeat (3) tick();
        check("rst_txd", 32'(Tx_Data), 32'd0);
        check("rst_txv", 32'(Tx_Data_valid), 32'd0);
        check("rst_sb", 32'(Sched_busy), 32'd0);
        check("rst_ovf", 32'(Ovf_err), 32'd0);
        RST = 1'b1;
        repeat (2) tick();

        // Single register read byte, latency from strobe to valid.
        u_rise = 0; u_hold_cfg = 10;
        n0 = log_b.size(); s = cyc + 1;
        send_rd(8'hA5);
        wait_idle(200);
        check_log("t1", n0, 1, 8'hA5, 8'h00, 8'h00);
        check("t1_latency", 32'(log_t[n0] - s), 32'd3);

        // ALU result, LSB first, second byte after busy rose and fell.
        n0 = log_b.size();
        send_alu(16'h1234);
        wait_idle(200);
        check_log("t2", n0, 2, 8'h34, 8'h12, 8'h00);
        check("t2_gap", 32'(log_t[n0 + 1] - log_t[n0]), 32'd13);

        // Simultaneous strobes after reset, then round-robin on the repeat.
        reset_pulse();
        n0 = log_b.size();
        RdData = 8'h11; Rd_valid = 1'b1; ALU_out = 16'hBEEF; ALU_out_valid = 1'b1; tick();
        wait_idle(300);
        check_log("t3a", n0, 3, 8'hEF, 8'hBE, 8'h11);
        n0 = log_b.size();
        RdData = 8'h11; Rd_valid = 1'b1; ALU_out = 16'hBEEF; ALU_out_valid = 1'b1; tick();
        wait_idle(300);
        check_log("t3b", n0, 3, 8'h11, 8'hEF, 8'hBE);

        // Overflow while a frame is in progress.
        n0 = log_b.size();
        send_alu(16'hCAFE);
        repeat (3) tick();
        send_rd(8'h01);
        send_rd(8'h02);
        check("t4_ovf_hi", 32'(Ovf_err), 32'd1);
        tick();
        check("t4_ovf_lo", 32'(Ovf_err), 32'd0);
        wait_idle(300);
        check_log("t4", n0, 3, 8'hFE, 8'hCA, 8'h01);

        // Busy never rises: the same byte is re-issued every BUSY_TO+1 cycles.
        u_stuck = 1'b1;
        n0 = log_b.size();
        send_rd(8'h5A);
        repeat (3 * (BT + 1) + 4) tick();
        check("t5_retries", 32'(log_b.size() - n0 >= 3), 32'd1);
        check("t5_gap1", 32'(log_t[n0 + 1] - log_t[n0]), 32'(BT + 1));
        check("t5_gap2", 32'(log_t[n0 + 2] - log_t[n0 + 1]), 32'(BT + 1));
        check("t5_b1", 32'(log_b[n0 + 1]), 32'h5A);
        u_stuck = 1'b0;
        wait_idle(300);
        check("t5_last", 32'(log_b[log_b.size() - 1]), 32'h5A);

        // Reset during WAIT_LO of the first ALU byte discards the frame.
        send_alu(16'h7788);
        n = 0;
        while (!Tx_Busy && n < 50) begin tick(); n++; end
        check("t6_busy_seen", 32'(Tx_Busy), 32'd1);
        repeat (2) tick();
        n0 = log_b.size();
        check("t6_first", 32'(log_b[n0 - 1]), 32'h88);
        RST = 1'b0;
        #1;
        check("t6_txd", 32'(Tx_Data), 32'd0);
        check("t6_txv", 32'(Tx_Data_valid), 32'd0);
        check("t6_sb", 32'(Sched_busy), 32'd0);
        check("t6_ovf", 32'(Ovf_err), 32'd0);
        repeat (2) tick();
        RST = 1'b1;
        repeat (60) tick();
        check("t6_no_more", 32'(log_b.size() - n0), 32'd0);
        check("t6_idle", 32'(Sched_busy), 32'd0);

        // Random traffic with random UART timing.
        for (int i = 0; i < 400; i++) begin
            u_rise     = int'($urandom_range(4, 0));
            u_hold_cfg = int'($urandom_range(8, 1));
            if ($urandom_range(5, 0) == 0) begin
                RdData = 8'($urandom()); Rd_valid = 1'b1;
            end
            if ($urandom_range(7, 0) == 0) begin
                ALU_out = 16'($urandom()); ALU_out_valid = 1'b1;
            end
            tick();
        end
        wait_idle(2000);
        check("rand_drained", 32'(m_bytes.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
